lut_loader: RTL
===============

# lut_loader

Write-side companion to the activation-function lookup: accepts a stream of 16-bit table words over a valid/ready handshake and writes them, in address order, into the RAM that the lookup reads. It replaces a fixed ROM image with a run-time-loadable table (sigmoid/tanh curves, scaled fixed point). It sits between the host/config path and the write port of the LUT RAM. It reports completion, a running checksum and protocol errors.

## Interface

- DEPTH, 888, number of table entries to write per load
- WIDTH, 16, table word width
- ADDR_W, $clog2(DEPTH), write address width (derived)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin a new load
- abort  in  1  one-cycle pulse: cancel a load in progress
- data_in  in  WIDTH  table word (signed, same format the lookup returns)
- data_valid  in  1  data_in valid
- data_ready  out  1  loader accepts data_in this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  WIDTH  RAM write data
- busy  out  1  load in progress
- done  out  1  sticky: last load completed with DEPTH words
- error  out  1  sticky: protocol violation since last start
- checksum  out  16  mod-2^16 sum of words accepted in current/last load

## Operation

- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE: start -> LOAD; clear done, error, checksum, word counter.
- LOAD: data_ready = 1 (combinational from state only). Accept = data_valid & data_ready. Each accept: counter increments, checksum += data_in (wrap-around, 16 bits), word registered to write port.
- Accept of word index DEPTH-1 -> DONE next cycle.
- DONE: done = 1 held; start -> LOAD with same clears as from IDLE.
- abort in LOAD -> IDLE; done stays 0, error set. Word presented in the abort cycle is not accepted (abort has priority over accept). abort outside LOAD ignored.
- start in LOAD ignored (no restart, no error).
- start and abort in same cycle: in LOAD abort wins; in IDLE/DONE start wins.
- data_valid while not in LOAD: word dropped, error set (except the cycle start is sampled, which still counts as a stray word, since data_ready is 0 that cycle).
- busy = (state == LOAD).
- Counter width ADDR_W; never wraps (load ends at DEPTH).

## Timing

- Reset values: data_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, checksum 0.
- start sampled cycle N -> busy/data_ready high cycle N+1.
- Word accepted cycle N -> wr_en=1, wr_addr=k, wr_data=word in cycle N+1 (one-cycle registered latency); wr_en low otherwise.
- Sustained throughput: one word per cycle, no bubbles inserted by the loader.
- checksum updated cycle N+1 after accept N.
- Last accept cycle N -> state DONE, done=1, busy=0, data_ready=0 in cycle N+1, coincident with last wr_en.
- abort in cycle N -> busy=0, error=1 in N+1; any write from an accept in N-1 still completes in N.
- Reset mid-load: all outputs to reset values immediately (async); no further wr_en; partial table contents undefined.

## Test plan

- Full load, DEPTH=8, words 1..8 back-to-back -> wr_addr 0..7 with wr_data 1..8, one per cycle; done=1 and busy=0 same cycle as 8th write; checksum=36; error=0.
- Same load with data_valid deasserted every other cycle -> identical writes and checksum, no wr_en in gap cycles, done after 8th write.
- Checksum wrap: DEPTH=2, words 0xFFFF, 0x0002 -> checksum=0x0001, done=1.
- Abort after 3 accepted words, data_valid held high -> exactly 3 writes (addr 0..2), busy=0, done=0, error=1; next start clears error, reload from addr 0.
- Stray data_valid in IDLE, then start pulse during LOAD -> error=1 from stray, no extra wr_en, start in LOAD leaves counter unchanged.
- Async rst asserted after 4 words of 8 -> all outputs 0 immediately, state IDLE; subsequent start + 8 words completes normally with done=1.

Source files
------------

// File: rtl/lut_loader.sv
// Loads a stream of table words into the activation LUT RAM in address order,
// tracking a running checksum, completion and protocol errors.
module lut_loader #(
  parameter int unsigned DEPTH  = 888,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum
);

  localparam int unsigned CSUM_W = 16;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   cnt_q,     cnt_d;
  logic [CSUM_W-1:0]   csum_q,    csum_d;
  logic                err_q,     err_d;
  logic                wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;

  // Next-state: abort beats accept in LOAD; start beats the stray-word check elsewhere,
  // but a word presented alongside start is still flagged.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = data_in;
          csum_d    = csum_q + CSUM_W'(data_in);
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          csum_d  = '0;
          err_d   = 1'b0;
        end
        if (data_valid) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign data_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign error      = err_q;
  assign checksum   = csum_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule
